// File: rtl/bit_population_counter_pipe_pkg.sv
// popcnt_pkg: width helpers shared by the popcount pipeline
package popcnt_pkg;
  function automatic int cnt_width(int w);
    return $clog2(w + 1);
  endfunction
  function automatic int n_chunks(int w, int c);
    return (w + c - 1) / c;
  endfunction
endpackage

// File: rtl/bit_population_counter_pipe_if.sv
// bit_population_counter_pipe_if: input stream plus count stream with valid/ready
interface bit_population_counter_pipe_if
  import popcnt_pkg::*;
#(parameter int WIDTH = 32);
  localparam int CNT_W = cnt_width(WIDTH);
  logic [WIDTH-1:0] data_i;
  logic [WIDTH-1:0] mask_i;
  logic invert_i;
  logic data_val_i;
  logic data_rdy_o;
  logic [CNT_W-1:0] data_o;
  logic zero_o;
  logic full_o;
  logic parity_o;
  logic data_val_o;
  logic data_rdy_i;
  modport master (
    output data_i, mask_i, invert_i, data_val_i, data_rdy_i,
    input data_rdy_o, data_o, zero_o, full_o, parity_o, data_val_o
  );
  modport slave (
    input data_i, mask_i, invert_i, data_val_i, data_rdy_i,
    output data_rdy_o, data_o, zero_o, full_o, parity_o, data_val_o
  );
endinterface

// File: rtl/bit_population_counter_pipe_chunk.sv
// popcnt_chunk: combinational set-bit count of one CHUNK-bit slice
module popcnt_chunk
  import popcnt_pkg::*;
#(parameter int CHUNK = 8) (
  input  logic [CHUNK-1:0] bits,
  output logic [cnt_width(CHUNK)-1:0] cnt
);
  localparam int PW = cnt_width(CHUNK);
  always_comb begin
    cnt = '0;
    for (int i = 0; i < CHUNK; i++) cnt = cnt + PW'(bits[i]);
  end
endmodule

// File: rtl/bit_population_counter_pipe.sv
// bit_population_counter_pipe: two-stage chunked popcount with valid/ready on both sides
module bit_population_counter_pipe
  import popcnt_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input logic clk_i,
  input logic rst_n_i,
  bit_population_counter_pipe_if.slave bus
);
  localparam int CNT_W = cnt_width(WIDTH);
  localparam int NCHUNK = n_chunks(WIDTH, CHUNK);
  localparam int PW = cnt_width(CHUNK);
  localparam int PADW = NCHUNK * CHUNK;
  logic [PADW-1:0] w;
  logic [PW-1:0] part [NCHUNK];
  logic [PW-1:0] s1_part [NCHUNK];
  logic [CNT_W-1:0] mcnt, s1_mcnt, sum;
  logic s1_val, s1_en, s2_en, accept;
  // the tail chunk sees zeros above WIDTH
  assign w = PADW'((bus.data_i ^ {WIDTH{bus.invert_i}}) & bus.mask_i);
  for (genvar g = 0; g < NCHUNK; g++) begin : g_chunk
    popcnt_chunk #(.CHUNK(CHUNK)) u_chunk (.bits(w[g*CHUNK +: CHUNK]), .cnt(part[g]));
  end
  popcnt_chunk #(.CHUNK(WIDTH)) u_mask (.bits(bus.mask_i), .cnt(mcnt));
  always_comb begin
    sum = '0;
    for (int i = 0; i < NCHUNK; i++) sum = sum + CNT_W'(s1_part[i]);
  end
  assign s2_en = !bus.data_val_o || bus.data_rdy_i;
  assign s1_en = !s1_val || s2_en;
  assign accept = bus.data_val_i && s1_en;
  assign bus.data_rdy_o = s1_en;
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      s1_val <= 1'b0;
      s1_part <= '{default: '0};
      s1_mcnt <= '0;
      bus.data_val_o <= 1'b0;
      bus.data_o <= '0;
      bus.zero_o <= 1'b0;
      bus.full_o <= 1'b0;
      bus.parity_o <= 1'b0;
    end else begin
      if (s1_en) begin
        s1_val <= accept;
        if (accept) begin
          s1_part <= part;
          s1_mcnt <= mcnt;
        end
      end
      if (s2_en) begin
        bus.data_val_o <= s1_val;
        if (s1_val) begin
          bus.data_o <= sum;
          bus.zero_o <= sum == '0;
          bus.full_o <= sum == s1_mcnt;
          bus.parity_o <= sum[0];
        end
      end
    end
  end
endmodule

// File: tb/tb_bit_population_counter_pipe.sv
// tb_bit_population_counter_pipe: directed and random checks of 32-bit and padded 20-bit counters
module tb_bit_population_counter_pipe;
  logic clk_i = 1'b0;
  logic rst_n_i = 1'b0;
  always #5 clk_i = ~clk_i;
  bit_population_counter_pipe_if #(.WIDTH(32)) a ();
  bit_population_counter_pipe_if #(.WIDTH(20)) b ();
  bit_population_counter_pipe #(.WIDTH(32), .CHUNK(8)) u32 (.clk_i(clk_i), .rst_n_i(rst_n_i), .bus(a.slave));
  bit_population_counter_pipe #(.WIDTH(20), .CHUNK(8)) u20 (.clk_i(clk_i), .rst_n_i(rst_n_i), .bus(b.slave));
  typedef struct {
    int cnt;
    logic full;
    int cyc;
  } exp_t;
  exp_t qa[$], qb[$];
  int n_chk, n_fail, cyc, outs_a, outs_b;
  bit lat_chk;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic exp_t mdl(logic [31:0] d, logic [31:0] m, logic inv, int wd);
    exp_t e;
    logic [31:0] keep;
    keep = (wd == 32) ? 32'hFFFF_FFFF : ((32'd1 << wd) - 32'd1);
    e.cnt = $countones((d ^ {32{inv}}) & m & keep);
    e.full = e.cnt == $countones(m & keep);
    e.cyc = 0;
    return e;
  endfunction

  task automatic check_out(string tag, exp_t e, logic [31:0] d, logic z, logic f, logic p);
    chk({tag, "_cnt"}, d, e.cnt);
    chk({tag, "_zero"}, 32'(z), 32'(e.cnt == 0));
    chk({tag, "_full"}, 32'(f), 32'(e.full));
    chk({tag, "_parity"}, 32'(p), 32'(e.cnt % 2));
    if (lat_chk) chk({tag, "_latency"}, cyc - e.cyc, 2);
  endtask

  task automatic tick();
    exp_t e;
    @(negedge clk_i);
    if (a.data_val_o && a.data_rdy_i) begin
      outs_a++;
      chk("a_expected_beat", 32'(qa.size() > 0), 1);
      if (qa.size() > 0) begin
        e = qa.pop_front();
        check_out("a", e, 32'(a.data_o), a.zero_o, a.full_o, a.parity_o);
      end
    end
    if (a.data_val_i && a.data_rdy_o) begin
      e = mdl(a.data_i, a.mask_i, a.invert_i, 32);
      e.cyc = cyc;
      qa.push_back(e);
    end
    if (b.data_val_o && b.data_rdy_i) begin
      outs_b++;
      chk("b_expected_beat", 32'(qb.size() > 0), 1);
      if (qb.size() > 0) begin
        e = qb.pop_front();
        check_out("b", e, 32'(b.data_o), b.zero_o, b.full_o, b.parity_o);
      end
    end
    if (b.data_val_i && b.data_rdy_o) begin
      e = mdl(32'(b.data_i), 32'(b.mask_i), b.invert_i, 20);
      e.cyc = cyc;
      qb.push_back(e);
    end
    cyc++;
    @(posedge clk_i);
    #1;
  endtask

  task automatic beat_a(string tag, logic [31:0] d, logic [31:0] m, logic inv,
                        int ecnt, logic ez, logic ef, logic ep);
    a.data_i = d;
    a.mask_i = m;
    a.invert_i = inv;
    a.data_val_i = 1'b1;
    tick();
    a.data_val_i = 1'b0;
    tick();
    chk({tag, "_val"}, 32'(a.data_val_o), 1);
    chk({tag, "_cnt"}, 32'(a.data_o), ecnt);
    chk({tag, "_zero"}, 32'(a.zero_o), 32'(ez));
    chk({tag, "_full"}, 32'(a.full_o), 32'(ef));
    chk({tag, "_parity"}, 32'(a.parity_o), 32'(ep));
    tick();
  endtask

  task automatic beat_b(string tag, logic [19:0] d, logic [19:0] m, int ecnt, logic ef);
    b.data_i = d;
    b.mask_i = m;
    b.invert_i = 1'b0;
    b.data_val_i = 1'b1;
    tick();
    b.data_val_i = 1'b0;
    tick();
    chk({tag, "_val"}, 32'(b.data_val_o), 1);
    chk({tag, "_cnt"}, 32'(b.data_o), ecnt);
    chk({tag, "_full"}, 32'(b.full_o), 32'(ef));
    tick();
  endtask

  initial begin
    int oa, ob;
    a.data_i = '0; a.mask_i = '0; a.invert_i = 1'b0; a.data_val_i = 1'b0; a.data_rdy_i = 1'b1;
    b.data_i = '0; b.mask_i = '0; b.invert_i = 1'b0; b.data_val_i = 1'b0; b.data_rdy_i = 1'b1;
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_val", 32'(a.data_val_o), 0);
    chk("rst_cnt", 32'(a.data_o), 0);
    chk("rst_zero", 32'(a.zero_o), 0);
    chk("rst_full", 32'(a.full_o), 0);
    chk("rst_parity", 32'(a.parity_o), 0);
    rst_n_i = 1'b1;
    #1;
    chk("rst_rdy", 32'(a.data_rdy_o), 1);
    tick();
    beat_a("basic", 32'hF0F0_0001, 32'hFFFF_FFFF, 1'b0, 9, 1'b0, 1'b0, 1'b1);
    beat_a("inv_mask16", 32'h0000_00FF, 32'h0000_FFFF, 1'b1, 8, 1'b0, 1'b0, 1'b0);
    beat_a("inv_maskhi", 32'h0000_00FF, 32'h0000_FF00, 1'b1, 8, 1'b0, 1'b1, 1'b0);
    beat_a("mask_zero", 32'h0000_00FF, 32'h0000_0000, 1'b1, 0, 1'b1, 1'b1, 1'b0);
    // backpressure: two beats fill the pipe, third waits
    oa = outs_a;
    a.data_rdy_i = 1'b0;
    a.mask_i = 32'hFFFF_FFFF;
    a.invert_i = 1'b0;
    a.data_val_i = 1'b1;
    a.data_i = 32'd1;
    tick();
    a.data_i = 32'd3;
    tick();
    a.data_i = 32'd7;
    for (int i = 0; i < 4; i++) begin
      chk("bp_rdy_low", 32'(a.data_rdy_o), 0);
      chk("bp_hold_val", 32'(a.data_val_o), 1);
      chk("bp_hold_cnt", 32'(a.data_o), 1);
      tick();
    end
    a.data_rdy_i = 1'b1;
    tick();
    a.data_val_i = 1'b0;
    repeat (4) tick();
    chk("bp_out_count", outs_a - oa, 3);
    chk("bp_q_empty", 32'(qa.size()), 0);
    // reset with two beats in flight
    a.data_rdy_i = 1'b0;
    a.data_val_i = 1'b1;
    a.data_i = 32'd5;
    tick();
    tick();
    a.data_val_i = 1'b0;
    chk("mid_val_before", 32'(a.data_val_o), 1);
    #2;
    rst_n_i = 1'b0;
    #1;
    chk("mid_rst_val_async", 32'(a.data_val_o), 0);
    chk("mid_rst_cnt", 32'(a.data_o), 0);
    qa.delete();
    qb.delete();
    @(posedge clk_i);
    #1;
    rst_n_i = 1'b1;
    a.data_rdy_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("mid_no_stale", 32'(a.data_val_o), 0);
    end
    beat_b("pad_all", 20'hFFFFF, 20'hFFFFF, 20, 1'b1);
    beat_b("pad_top", 20'h80000, 20'hFFFFF, 1, 1'b0);
    // full throughput on both instances
    lat_chk = 1'b1;
    oa = outs_a;
    ob = outs_b;
    for (int i = 0; i < 100; i++) begin
      a.data_i = $urandom;
      a.mask_i = $urandom;
      a.invert_i = 1'($urandom_range(0, 1));
      a.data_val_i = 1'b1;
      b.data_i = 20'($urandom);
      b.mask_i = 20'($urandom);
      b.invert_i = 1'($urandom_range(0, 1));
      b.data_val_i = 1'b1;
      tick();
    end
    a.data_val_i = 1'b0;
    b.data_val_i = 1'b0;
    repeat (3) tick();
    lat_chk = 1'b0;
    chk("rand_a_outs", outs_a - oa, 100);
    chk("rand_b_outs", outs_b - ob, 100);
    chk("rand_a_q_empty", 32'(qa.size()), 0);
    chk("rand_b_q_empty", 32'(qb.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
